// File: rtl/i_execute.sv
// Execute stage: ALU control decode, ALU, branch resolution and the EX/MEM pipeline register.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by defining EX_FORWARD_EN.
module i_execute (
  input  logic        CLK,
  input  logic        RST,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        AluSrc_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        RegDst_in,
  input  logic        MemtoReg_in,
  input  logic [1:0]  AluOp_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] readdata1_in,
  input  logic [31:0] readdata2_in,
  input  logic [31:0] sigext_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] writedata_out,
  output logic [4:0]  write_reg_out,
  output logic [31:0] branch_target_out,
  output logic        branch_taken_out,
  output logic        zero_out,
  output logic        jump_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [31:0] r_alu_result;
  logic [31:0] r_writedata;
  logic [4:0]  r_write_reg;
  logic [31:0] r_branch_target;
  logic        r_branch_taken;
  logic        r_zero;
  logic        r_jump;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_reg_write;
  logic        r_memto_reg;

  logic [2:0]  w_alu_op;
  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic [4:0]  w_write_reg;
  logic [31:0] w_branch_target;

  always_comb begin
    w_alu_op = ALU_ADD;
    case (AluOp_in)
      2'b00: w_alu_op = ALU_ADD;
      2'b01: w_alu_op = ALU_SUB;
      2'b11: w_alu_op = ALU_OR;
      default: begin
        case (sigext_in[5:0])
          6'h20:   w_alu_op = ALU_ADD;
          6'h22:   w_alu_op = ALU_SUB;
          6'h24:   w_alu_op = ALU_AND;
          6'h25:   w_alu_op = ALU_OR;
          6'h2A:   w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_ADD;
        endcase
      end
    endcase
  end

`ifdef EX_FORWARD_EN
  // EX/MEM wins over MEM/WB; r0 is hardwired zero so it is never bypassed.
  always_comb begin
    if (r_reg_write && (r_write_reg != 5'd0) && (r_write_reg == rs_in))
      w_op_a = r_alu_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_in))
      w_op_a = memwb_data;
    else
      w_op_a = readdata1_in;
  end

  always_comb begin
    if (r_reg_write && (r_write_reg != 5'd0) && (r_write_reg == rt_in))
      w_fwd_b = r_alu_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_in))
      w_fwd_b = memwb_data;
    else
      w_fwd_b = readdata2_in;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{memwb_regwrite, memwb_rd, memwb_data, rs_in};
  assign w_op_a  = readdata1_in;
  assign w_fwd_b = readdata2_in;
`endif

  assign w_op_b = AluSrc_in ? sigext_in : w_fwd_b;

  always_comb begin
    w_alu_result = w_op_a + w_op_b;
    case (w_alu_op)
      ALU_SUB: w_alu_result = w_op_a - w_op_b;
      ALU_AND: w_alu_result = w_op_a & w_op_b;
      ALU_OR:  w_alu_result = w_op_a | w_op_b;
      ALU_SLT: w_alu_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
      default: w_alu_result = w_op_a + w_op_b;
    endcase
  end

  assign w_zero          = (w_alu_result == 32'd0);
  assign w_write_reg     = RegDst_in ? rd_in : rt_in;
  assign w_branch_target = npc_in + {sigext_in[29:0], 2'b00};

  // Flush beats stall: data fields still load, control bits become a bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_result    <= 32'd0;
      r_writedata     <= 32'd0;
      r_write_reg     <= 5'd0;
      r_branch_target <= 32'd0;
      r_zero          <= 1'b0;
      r_memto_reg     <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_jump          <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
    end else begin
      if (flush || !stall) begin
        r_alu_result    <= w_alu_result;
        r_writedata     <= w_fwd_b;
        r_write_reg     <= w_write_reg;
        r_branch_target <= w_branch_target;
        r_zero          <= w_zero;
        r_memto_reg     <= MemtoReg_in;
      end
      if (flush) begin
        r_branch_taken <= 1'b0;
        r_jump         <= 1'b0;
        r_mem_read     <= 1'b0;
        r_mem_write    <= 1'b0;
        r_reg_write    <= 1'b0;
      end else if (!stall) begin
        r_branch_taken <= branch_in & w_zero;
        r_jump         <= jump_in;
        r_mem_read     <= MemRead_in;
        r_mem_write    <= MemWrite_in;
        r_reg_write    <= RegWrite_in;
      end
    end
  end

  assign alu_result_out    = r_alu_result;
  assign writedata_out     = r_writedata;
  assign write_reg_out     = r_write_reg;
  assign branch_target_out = r_branch_target;
  assign branch_taken_out  = r_branch_taken;
  assign zero_out          = r_zero;
  assign jump_out          = r_jump;
  assign MemRead_out       = r_mem_read;
  assign MemWrite_out      = r_mem_write;
  assign RegWrite_out      = r_reg_write;
  assign MemtoReg_out      = r_memto_reg;

endmodule

// File: doc/i_execute.md
# i_execute

Execute stage of the five-stage pipelined processor. It consumes the ID/EX bundle that the decode stage registers and derives the ALU operation from AluOp and funct. It performs the ALU operation and resolves branches (zero flag, target), then registers everything into the EX/MEM pipeline register for the memory stage. It supports stall (hold), flush (bubble insertion) and optional operand forwarding.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- CLK  in  1  pipeline clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- branch_in, jump_in, AluSrc_in, MemRead_in, MemWrite_in, RegWrite_in, RegDst_in, MemtoReg_in  in  1 each  ID/EX control bits
- AluOp_in  in  2  ALU class: 00 add, 01 sub, 10 R-type (funct), 11 or
- npc_in  in  32  PC+4 of the instruction
- readdata1_in, readdata2_in  in  32  register file operands rs, rt
- sigext_in  in  32  sign-extended immediate; bits [5:0] are funct
- rs_in, rt_in, rd_in  in  5  source/destination indices (rt_in = instr[20:16], rd_in = instr[15:11])
- stall  in  1  hold EX/MEM register
- flush  in  1  load a bubble into EX/MEM
- memwb_regwrite  in  1, memwb_rd  in  5, memwb_data  in  32  write-back bypass source
- alu_result_out  out  32  ALU result / memory address
- writedata_out  out  32  store data (post-forwarding rt value)
- write_reg_out  out  5  destination register
- branch_target_out  out  32  npc_in + (sigext_in << 2)
- branch_taken_out  out  1  branch_in & zero
- zero_out  out  1  ALU result == 0
- jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out  out  1  forwarded control

## Operation
- ALU control:
  - AluOp 00: add.
  - AluOp 01: sub.
  - AluOp 11: or.
  - AluOp 10: decoded from funct. 0x20 → add, 0x22 → sub, 0x24 → and, 0x25 → or, 0x2A → slt (signed, result 1/0). Any other funct → add.
- Operand B = AluSrc_in ? sigext_in : forwarded rt.
- All add/sub arithmetic is 32-bit modulo; no overflow detection or trap.
- write_reg = RegDst_in ? rd_in : rt_in.
- Branch target is computed unconditionally; adder wraps modulo 2^32.
- Per-cycle update of the EX/MEM register, in priority order:
  - flush=1: RegWrite, MemRead, MemWrite, jump, branch_taken all load 0; data fields load normally. Flush overrides stall.
  - stall=1, flush=0: every EX/MEM field holds its value.
  - Otherwise: all fields load the newly computed values.
- Forwarding (EX_FORWARD_EN, per operand rs/rt):
  - First choice: own EX/MEM (RegWrite_out=1, write_reg_out≠0, write_reg_out==src) → alu_result_out.
  - Otherwise: MEM/WB (memwb_regwrite=1, memwb_rd≠0, memwb_rd==src) → memwb_data.
  - Otherwise: register-file value.
  - EX/MEM takes priority over MEM/WB when both match.
  - Register 0 is never forwarded.
  - Loads return EX/MEM alu_result (the address); load-use hazards are the hazard unit's responsibility (it asserts stall/flush).

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- ALU, forwarding muxes and branch logic are combinational within the cycle.
- RST low: all outputs go to 0 immediately, independent of CLK, and stay 0 while low.
- First update is the first rising edge after RST deasserts.
- Reset mid-stall or mid-flush discards pending state; no memory of it after release.

## Configuration
- EX_FORWARD_EN defined: forwarding muxes present as described.
- EX_FORWARD_EN undefined:
  - Operands come straight from readdata1_in/readdata2_in.
  - memwb_* inputs are ignored but ports remain.
  - Behaviour is otherwise identical.

## Test plan
- R-type add: AluOp=10, funct=0x20, rs=5, rt=7, RegDst=1, rd=3, RegWrite=1 → next edge alu_result_out=12, write_reg_out=3, RegWrite_out=1.
- Load address: AluSrc=1, AluOp=00, rs=0x100, sigext=0xFFFFFFFC, RegDst=0, rt index=8, MemRead=1 → alu_result_out=0xFC, write_reg_out=8, MemRead_out=1.
- Branch: AluOp=01, branch=1, rs=rt=9, npc=0x40, sigext=3 → branch_taken_out=1, branch_target_out=0x4C, zero_out=1. Same with rt=8 → branch_taken_out=0.
- Stall/flush:
  - stall held 2 cycles → outputs unchanged both cycles.
  - stall=1 and flush=1 together → RegWrite_out, MemWrite_out, MemRead_out, branch_taken_out = 0.
- Forwarding: add r3←5+7 followed by sub rd=4, rs=r3, stale readdata1=0, rt=2.
  - With EX_FORWARD_EN → alu_result_out=10.
  - Without EX_FORWARD_EN → 0xFFFFFFFE.
  - With memwb_rd=3 and memwb_data=1 also matching → still 10 (EX/MEM priority).
- Async reset: drop RST mid-cycle while outputs are nonzero → all outputs 0 before the next CLK edge.
